// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, special-op encodings, controller states and instruction field positions.
package alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_LD, ALU_NOP
    } alu_op_t;

    localparam logic [2:0] OP_SPECIAL = 3'd7;
    localparam logic [4:0] SPC_CLC = 5'b00001;
    localparam logic [4:0] SPC_SEC = 5'b00010;

    localparam int OP_MSB        = 7;
    localparam int OP_LSB        = 5;
    localparam int USE_CARRY_BIT = 4;
    localparam int SRC_MEM_BIT   = 3;
    localparam int IDX_MSB       = 2;

    typedef enum logic [1:0] {IDLE, DECODE, MEM_WAIT, EXEC} state_t;
endpackage

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction handshake, memory request and ALU/accumulator control bundle.
interface alu_ctrl_if;
    logic       ins_valid;
    logic [7:0] ins;
    logic       ins_ready;
    logic [2:0] reg_addr;
    logic [2:0] mem_addr;
    logic       mem_req;
    logic       mem_ack;
    logic       src_sel;
    logic [2:0] alu_code;
    logic       ci;
    logic       co;
    logic       accu_we;
    logic       carry_flag;
    logic       err;
    logic [7:0] retire_cnt;

    modport master (
        input  ins_valid, ins, mem_ack, co,
        output ins_ready, reg_addr, mem_addr, mem_req, src_sel, alu_code,
               ci, accu_we, carry_flag, err, retire_cnt
    );
    modport slave (
        output ins_valid, ins, mem_ack, co,
        input  ins_ready, reg_addr, mem_addr, mem_req, src_sel, alu_code,
               ci, accu_we, carry_flag, err, retire_cnt
    );
endinterface

// File: rtl/wait_timer.sv
// wait_timer: 8-bit clear/count counter; expire marks the LIMIT-th consecutive enabled cycle.
module wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 8'd1;
    end

    assign expire = en && cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: multi-cycle sequencer driving the 8-bit ALU/accumulator from one instruction byte per handshake.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_ctrl_if.master      bus
);
    state_t     state, nxt;
    logic [7:0] ir;
    logic [7:0] retire_cnt;
    logic       carry_flag, err;
    logic       busy, in_wait, expire, special;
    logic [2:0] op;

    assign op      = ir[OP_MSB:OP_LSB];
    assign special = op == OP_SPECIAL;
    assign busy    = state != IDLE;
    assign in_wait = state == MEM_WAIT;

    wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!in_wait),
        .en     (in_wait),
        .expire (expire)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = bus.ins_valid ? DECODE : IDLE;
            DECODE:   nxt = special ? IDLE : ir[SRC_MEM_BIT] ? MEM_WAIT : EXEC;
            MEM_WAIT: nxt = bus.mem_ack ? EXEC : expire ? IDLE : MEM_WAIT;
            default:  nxt = IDLE;
        endcase
    end

    // Outputs decode from state and IR only, so no input reaches an output combinationally.
    assign bus.ins_ready  = !busy;
    assign bus.alu_code   = busy ? op : ALU_NOP;
    assign bus.src_sel    = busy & ir[SRC_MEM_BIT];
    assign bus.reg_addr   = busy ? ir[IDX_MSB:0] : 3'd0;
    assign bus.mem_addr   = busy ? ir[IDX_MSB:0] : 3'd0;
    assign bus.mem_req    = in_wait;
    assign bus.accu_we    = state == EXEC;
    assign bus.ci         = state == EXEC && (op == ALU_ADD || op == ALU_SUB) && ir[USE_CARRY_BIT] && carry_flag;
    assign bus.carry_flag = carry_flag;
    assign bus.err        = err;
    assign bus.retire_cnt = retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ir         <= '0;
            carry_flag <= 1'b0;
            err        <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.ins_valid)
                ir <= bus.ins;
            if (state == DECODE && special && ir[4:0] == SPC_SEC)
                carry_flag <= 1'b1;
            else if (state == DECODE && special && ir[4:0] == SPC_CLC)
                carry_flag <= 1'b0;
            else if (state == EXEC)
                carry_flag <= bus.co;
            if (in_wait && !bus.mem_ack && expire)
                err <= 1'b1;
            if (state == EXEC || (state == DECODE && special))
                retire_cnt <= retire_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: drives alu_ctrl with an environment ALU/accumulator and checks it against an instruction-level model.
module tb_alu_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_if ifc();
    alu_ctrl #(.MEM_TIMEOUT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    logic [7:0] rf [8];
    logic [7:0] dmem [8];
    logic [7:0] acc, res, opb, acc_ld_v;
    logic       acc_ld, co_e;
    int         total = 0;
    int         bad = 0;

    logic [7:0] m_acc, m_ret;
    logic       m_c, m_err;

    localparam logic [23:0] RESET_OUTS = {1'b1, 3'd7, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    always_comb begin
        opb  = ifc.src_sel ? dmem[ifc.mem_addr] : rf[ifc.reg_addr];
        co_e = 1'b0;
        res  = acc;
        case (ifc.alu_code)
            3'd0: {co_e, res} = {1'b0, acc} + {1'b0, opb} + {8'd0, ifc.ci};
            3'd1: {co_e, res} = {1'b0, acc} - {1'b0, opb} - {8'd0, ifc.ci};
            3'd2: res = acc & opb;
            3'd3: res = acc | opb;
            3'd4: res = acc ^ opb;
            3'd5: res = ~opb;
            3'd6: res = opb;
            default: res = acc;
        endcase
    end
    assign ifc.co = co_e;

    always @(posedge clk) begin
        if (acc_ld)
            acc <= acc_ld_v;
        else if (ifc.accu_we)
            acc <= res;
    end

    function automatic logic [23:0] outs();
        return {ifc.ins_ready, ifc.alu_code, ifc.mem_req, ifc.src_sel, ifc.reg_addr, ifc.mem_addr,
                ifc.accu_we, ifc.ci, ifc.carry_flag, ifc.err, ifc.retire_cnt};
    endfunction

    task automatic apply_reset;
        ifc.ins_valid = 1'b0;
        ifc.mem_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_ret = 8'd0;
        m_c = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic set_acc(input logic [7:0] v);
        acc_ld = 1'b1;
        acc_ld_v = v;
        @(posedge clk);
        #1 acc_ld = 1'b0;
        m_acc = v;
    endtask

    // d = MEM_WAIT cycles before the ack cycle; d < 0 never acks.
    task automatic run_ins(input logic [7:0] x, input int d, output int cyc, output int we_n, output int req_n,
                           output int we_at, output logic ci_s, output logic [2:0] ma, output logic ss);
        cyc = 0; we_n = 0; req_n = 0; we_at = 0; ci_s = 1'b0; ma = 3'd0; ss = 1'b0;
        for (int k = 0; k < 50 && !ifc.ins_ready; k++) @(negedge clk);
        ifc.ins = x;
        ifc.ins_valid = 1'b1;
        @(posedge clk);
        #1 ifc.ins_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cyc++;
            if (ifc.ins_ready) break;
            if (ifc.accu_we) begin
                we_n++;
                we_at = cyc;
                ci_s = ifc.ci;
            end
            if (ifc.mem_req) begin
                req_n++;
                ma = ifc.mem_addr;
                ss = ifc.src_sel;
                ifc.mem_ack = d >= 0 && req_n == d + 1;
            end else
                ifc.mem_ack = 1'($urandom_range(0, 1));
            ifc.ins_valid = 1'($urandom_range(0, 1));
            ifc.ins = 8'($urandom);
        end
        ifc.ins_valid = 1'b0;
        ifc.mem_ack = 1'b0;
    endtask

    task automatic model_ins(input logic [7:0] x, input int d, output int e_cyc, output int e_we,
                             output int e_req, output logic e_ci);
        int op, a, bv, r;
        op = int'(x[7:5]);
        e_ci = 1'b0; e_we = 0; e_req = 0; r = 0;
        if (op == 7) begin
            e_cyc = 2;
            if (x[4:0] == 5'd1) m_c = 1'b0;
            else if (x[4:0] == 5'd2) m_c = 1'b1;
            m_ret = m_ret + 8'd1;
        end else if (x[3] && d < 0) begin
            e_cyc = 17;
            e_req = 15;
            m_err = 1'b1;
        end else begin
            e_ci = x[4] && m_c && op < 2;
            a = int'(m_acc);
            bv = int'(x[3] ? dmem[x[2:0]] : rf[x[2:0]]);
            case (op)
                0: r = a + bv + int'(e_ci);
                1: r = a - bv - int'(e_ci);
                2: r = a & bv;
                3: r = a | bv;
                4: r = a ^ bv;
                5: r = 255 - bv;
                default: r = bv;
            endcase
            m_c = r > 255 || r < 0;
            m_acc = 8'(r);
            e_we = 1;
            e_req = x[3] ? d + 1 : 0;
            e_cyc = x[3] ? d + 4 : 3;
            m_ret = m_ret + 8'd1;
        end
    endtask

    task automatic test_reset;
        apply_reset();
        total++;
        if (outs() !== RESET_OUTS) begin
            bad++;
            $display("FAIL reset_outs: got %h want %h", outs(), RESET_OUTS);
        end
    endtask

    task automatic test_add;
        int cyc, we_n, req_n, we_at, ec, ew, er;
        logic ci_s, ss, eci;
        logic [2:0] ma;
        rf[2] = 8'h05;
        set_acc(8'h03);
        model_ins(8'h02, 0, ec, ew, er, eci);
        run_ins(8'h02, 0, cyc, we_n, req_n, we_at, ci_s, ma, ss);
        total++;
        if (we_at !== 2) begin bad++; $display("FAIL add_we_cycle: got %0d want 2", we_at); end
        total++;
        if (acc !== 8'h08) begin bad++; $display("FAIL add_acc: got %h want 08", acc); end
        total++;
        if (ifc.carry_flag !== 1'b0) begin bad++; $display("FAIL add_carry: got %b want 0", ifc.carry_flag); end
        total++;
        if (ifc.retire_cnt !== 8'd1) begin bad++; $display("FAIL add_retire: got %0d want 1", ifc.retire_cnt); end
        total++;
        if (cyc !== 3) begin bad++; $display("FAIL add_next_accept: got %0d want 3", cyc); end
    endtask

    task automatic test_carry;
        int cyc, we_n, req_n, we_at, ec, ew, er;
        logic ci_s, ss, eci;
        logic [2:0] ma;
        model_ins(8'hE2, 0, ec, ew, er, eci);
        run_ins(8'hE2, 0, cyc, we_n, req_n, we_at, ci_s, ma, ss);
        total++;
        if (cyc !== 2 || we_n !== 0) begin bad++; $display("FAIL sec_timing: got cyc=%0d we=%0d want cyc=2 we=0", cyc, we_n); end
        total++;
        if (ifc.carry_flag !== 1'b1) begin bad++; $display("FAIL sec_carry: got %b want 1", ifc.carry_flag); end
        rf[1] = 8'h00;
        set_acc(8'hFF);
        model_ins(8'h11, 0, ec, ew, er, eci);
        run_ins(8'h11, 0, cyc, we_n, req_n, we_at, ci_s, ma, ss);
        total++;
        if (ci_s !== 1'b1) begin bad++; $display("FAIL adc_ci: got %b want 1", ci_s); end
        total++;
        if (acc !== 8'h00 || ifc.carry_flag !== 1'b1) begin
            bad++; $display("FAIL adc_result: got acc=%h c=%b want acc=00 c=1", acc, ifc.carry_flag);
        end
        model_ins(8'h41, 0, ec, ew, er, eci);
        run_ins(8'h41, 0, cyc, we_n, req_n, we_at, ci_s, ma, ss);
        total++;
        if (ifc.carry_flag !== 1'b0) begin bad++; $display("FAIL and_clears_carry: got %b want 0", ifc.carry_flag); end
    endtask

    task automatic test_ld_mem;
        int cyc, we_n, req_n, we_at, ec, ew, er;
        logic ci_s, ss, eci;
        logic [2:0] ma;
        logic [7:0] r0;
        dmem[3] = 8'hA5;
        r0 = ifc.retire_cnt;
        model_ins(8'hCB, 4, ec, ew, er, eci);
        run_ins(8'hCB, 4, cyc, we_n, req_n, we_at, ci_s, ma, ss);
        total++;
        if (req_n !== 5) begin bad++; $display("FAIL ld_memreq_len: got %0d want 5", req_n); end
        total++;
        if (ma !== 3'd3 || ss !== 1'b1) begin bad++; $display("FAIL ld_addr_sel: got addr=%0d sel=%b want addr=3 sel=1", ma, ss); end
        total++;
        if (we_at !== 7 || we_n !== 1) begin bad++; $display("FAIL ld_we: got at=%0d n=%0d want at=7 n=1", we_at, we_n); end
        total++;
        if (acc !== 8'hA5) begin bad++; $display("FAIL ld_acc: got %h want a5", acc); end
        total++;
        if (ifc.retire_cnt !== r0 + 8'd1) begin bad++; $display("FAIL ld_retire: got %0d want %0d", ifc.retire_cnt, r0 + 8'd1); end
    endtask

    task automatic test_ack_at_limit;
        int cyc, we_n, req_n, we_at, ec, ew, er;
        logic ci_s, ss, eci;
        logic [2:0] ma;
        dmem[3] = 8'h3C;
        model_ins(8'hCB, 14, ec, ew, er, eci);
        run_ins(8'hCB, 14, cyc, we_n, req_n, we_at, ci_s, ma, ss);
        total++;
        if (ifc.err !== 1'b0 || we_n !== 1 || req_n !== 15) begin
            bad++; $display("FAIL ack_at_limit: got err=%b we=%0d req=%0d want err=0 we=1 req=15", ifc.err, we_n, req_n);
        end
        total++;
        if (acc !== 8'h3C) begin bad++; $display("FAIL ack_at_limit_acc: got %h want 3c", acc); end
    endtask

    task automatic test_timeout;
        int cyc, we_n, req_n, we_at, ec, ew, er;
        logic ci_s, ss, eci;
        logic [2:0] ma;
        logic [7:0] r0, a0;
        r0 = ifc.retire_cnt;
        a0 = acc;
        model_ins(8'hCB, -1, ec, ew, er, eci);
        run_ins(8'hCB, -1, cyc, we_n, req_n, we_at, ci_s, ma, ss);
        total++;
        if (ifc.err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", ifc.err); end
        total++;
        if (we_n !== 0 || acc !== a0) begin bad++; $display("FAIL timeout_nowrite: got we=%0d acc=%h want we=0 acc=%h", we_n, acc, a0); end
        total++;
        if (ifc.retire_cnt !== r0) begin bad++; $display("FAIL timeout_retire: got %0d want %0d", ifc.retire_cnt, r0); end
        total++;
        if (req_n !== 15 || cyc !== 17) begin bad++; $display("FAIL timeout_len: got req=%0d cyc=%0d want req=15 cyc=17", req_n, cyc); end
    endtask

    task automatic test_random;
        int cyc, we_n, req_n, we_at, ec, ew, er, d;
        logic ci_s, ss, eci;
        logic [2:0] ma;
        logic [7:0] x;
        for (int i = 0; i < 8; i++) begin
            rf[i] = 8'($urandom);
            dmem[i] = 8'($urandom);
        end
        for (int n = 0; n < 80; n++) begin
            x = 8'($urandom);
            if ($urandom_range(0, 4) == 0) x = $urandom_range(0, 1) ? 8'hE1 : 8'hE2;
            d = $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(0, 14));
            model_ins(x, d, ec, ew, er, eci);
            run_ins(x, d, cyc, we_n, req_n, we_at, ci_s, ma, ss);
            total++;
            if (cyc !== ec || we_n !== ew || req_n !== er) begin
                bad++; $display("FAIL rand_timing ins=%h: got cyc=%0d we=%0d req=%0d want cyc=%0d we=%0d req=%0d", x, cyc, we_n, req_n, ec, ew, er);
            end
            total++;
            if (acc !== m_acc || ifc.carry_flag !== m_c) begin
                bad++; $display("FAIL rand_result ins=%h: got acc=%h c=%b want acc=%h c=%b", x, acc, ifc.carry_flag, m_acc, m_c);
            end
            total++;
            if (ifc.retire_cnt !== m_ret || ifc.err !== m_err) begin
                bad++; $display("FAIL rand_status ins=%h: got ret=%0d err=%b want ret=%0d err=%b", x, ifc.retire_cnt, ifc.err, m_ret, m_err);
            end
            if (ew == 1) begin
                total++;
                if (ci_s !== eci || we_at !== ec - 1) begin
                    bad++; $display("FAIL rand_exec ins=%h: got ci=%b at=%0d want ci=%b at=%0d", x, ci_s, we_at, eci, ec - 1);
                end
            end
            if (er > 0) begin
                total++;
                if (ma !== x[2:0] || ss !== 1'b1) begin
                    bad++; $display("FAIL rand_memaddr ins=%h: got addr=%0d sel=%b want addr=%0d sel=1", x, ma, ss, x[2:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc, we_n, req_n, we_at, ec, ew, er, slow;
        logic ci_s, ss, eci;
        logic [2:0] ma;
        apply_reset();
        slow = 0;
        for (int n = 0; n < 256; n++) begin
            model_ins(8'hE0, 0, ec, ew, er, eci);
            run_ins(8'hE0, 0, cyc, we_n, req_n, we_at, ci_s, ma, ss);
            if (cyc != 2 || we_n != 0) slow++;
            if (n == 254) begin
                total++;
                if (ifc.retire_cnt !== 8'd255) begin bad++; $display("FAIL nop_retire_255: got %0d want 255", ifc.retire_cnt); end
            end
        end
        total++;
        if (slow !== 0) begin bad++; $display("FAIL nop_back_to_back: got %0d off-timing NOPs want 0", slow); end
        total++;
        if (ifc.retire_cnt !== 8'd0 || ifc.err !== 1'b0) begin
            bad++; $display("FAIL nop_wrap: got ret=%0d err=%b want ret=0 err=0", ifc.retire_cnt, ifc.err);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] a0;
        a0 = acc;
        ifc.ins = 8'hCB;
        ifc.ins_valid = 1'b1;
        @(posedge clk);
        #1 ifc.ins_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (ifc.mem_req !== 1'b1) begin bad++; $display("FAIL mid_in_wait: got memreq=%b want 1", ifc.mem_req); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (outs() !== RESET_OUTS) begin bad++; $display("FAIL mid_reset_outs: got %h want %h", outs(), RESET_OUTS); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (acc !== a0 || outs() !== RESET_OUTS) begin
            bad++; $display("FAIL mid_after_release: got acc=%h outs=%h want acc=%h outs=%h", acc, outs(), a0, RESET_OUTS);
        end
    endtask

    initial begin
        ifc.ins_valid = 1'b0;
        ifc.ins = 8'h00;
        ifc.mem_ack = 1'b0;
        acc_ld = 1'b0;
        acc_ld_v = 8'h00;
        m_acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rf[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        test_reset();
        test_add();
        test_carry();
        test_ld_mem();
        test_ack_at_limit();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
